// File: rtl/magma_decrypt.sv
// Magma (GOST R 34.12-2015) block decryptor: one Feistel round per clock,
// 32 rounds per block, with an internal copy of the key captured at start.
module magma_decrypt (
  input  logic         clk,
  input  logic         reset_,
  input  logic         start,
  input  logic [63:0]  data_in,
  input  logic [255:0] key,
  output logic [63:0]  data_out,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // pi7..pi0; entry x of each table sits in nibble x of its 64-bit word
  localparam logic [7:0][63:0] SBOX = {
    64'h2BC96AF43850DE71,
    64'h73AD0B4FC19652E8,
    64'h0E34187BAC296FD5,
    64'hC24BE390D618A5F7,
    64'hB9E35A076F4D128C,
    64'h069C471EDAF2853B,
    64'hF0DB74E1C5A93286,
    64'h1F307D8E9B5A264C
  };

  function automatic logic [31:0] round_g(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] t;
    logic [31:0] s;
    t = a + k;
    s = 32'd0;
    for (int i = 0; i < 8; i++) begin
      s[4*i +: 4] = SBOX[i][{t[4*i +: 4], 2'b00} +: 4];
    end
    return {s[20:0], s[31:21]};
  endfunction

  state_t         state_q, state_d;
  logic [4:0]     r_q, r_d;
  logic [31:0]    a1_q, a1_d, a0_q, a0_d;
  logic [255:0]   key_q, key_d;
  logic [63:0]    dout_q, dout_d;
  logic [2:0]     kidx_s;
  logic [31:0]    rkey_s;
  logic [31:0]    feistel_s;

  // Round r uses K1..K8 for the first eight rounds, then K8..K1 repeatedly
  assign kidx_s    = (r_q[4:3] == 2'b00) ? r_q[2:0] : ~r_q[2:0];
  assign rkey_s    = key_q[{~kidx_s, 5'b00000} +: 32];
  assign feistel_s = round_g(a0_q, rkey_s) ^ a1_q;

  // State register
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RUN : IDLE;
      RUN:     state_d = (r_q == 5'd31) ? FIN : RUN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      IDLE:    begin busy = 1'b0; done = 1'b0; end
      RUN:     begin busy = 1'b1; done = 1'b0; end
      FIN:     begin busy = 1'b0; done = 1'b1; end
      default: begin busy = 1'b0; done = 1'b0; end
    endcase
  end

  // Datapath next values: capture at start, one round per RUN cycle
  always_comb begin
    r_d    = r_q;
    a1_d   = a1_q;
    a0_d   = a0_q;
    key_d  = key_q;
    dout_d = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a1_d  = data_in[63:32];
          a0_d  = data_in[31:0];
          key_d = key;
          r_d   = 5'd0;
        end else begin
          r_d   = r_q;
        end
      end
      RUN: begin
        a1_d = a0_q;
        a0_d = feistel_s;
        // Last round: store with the final half-swap undone
        if (r_q == 5'd31) begin
          r_d    = r_q;
          dout_d = {feistel_s, a0_q};
        end else begin
          r_d    = r_q + 5'd1;
        end
      end
      FIN:     r_d = r_q;
      default: r_d = r_q;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_q    <= 5'd0;
      a1_q   <= 32'd0;
      a0_q   <= 32'd0;
      key_q  <= 256'd0;
      dout_q <= 64'd0;
    end else begin
      r_q    <= r_d;
      a1_q   <= a1_d;
      a0_q   <= a0_d;
      key_q  <= key_d;
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: tb/tb_magma_decrypt.sv
// Self-checking bench for magma_decrypt against a behavioural Magma model.
module tb_magma_decrypt;

  logic         clk;
  logic         reset_;
  logic         start;
  logic [63:0]  data_in;
  logic [255:0] key;
  logic [63:0]  data_out;
  logic         done;
  logic         busy;

  int tests_run;
  int tests_failed;

  localparam logic [255:0] KEY_STD = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [63:0]  CT_STD  = 64'h4ee901e5c2d8ca3d;
  localparam logic [63:0]  PT_STD  = 64'hfedcba9876543210;

  int sb [8][16] = '{
    '{12, 4, 6, 2,10, 5,11, 9,14, 8,13, 7, 0, 3,15, 1},
    '{ 6, 8, 2, 3, 9,10, 5,12, 1,14, 4, 7,11,13, 0,15},
    '{11, 3, 5, 8, 2,15,10,13,14, 1, 7, 4,12, 9, 6, 0},
    '{12, 8, 2, 1,13, 4,15, 6, 7, 0,10, 5, 3,14, 9,11},
    '{ 7,15, 5,10, 8, 1, 6,13, 0, 9, 3,14,11, 4, 2,12},
    '{ 5,13,15, 6, 9, 2,12,10,11, 7, 8, 1, 4, 3,14, 0},
    '{ 8,14, 2, 5, 6, 9, 1,12,15, 4,11, 0,13,10, 3, 7},
    '{ 1, 7,14,13, 0, 5, 8, 3, 4,15,10, 6, 9,12,11, 2}
  };

  magma_decrypt dut (
    .clk      (clk),
    .reset_   (reset_),
    .start    (start),
    .data_in  (data_in),
    .key      (key),
    .data_out (data_out),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_g(input logic [31:0] a, input logic [31:0] k);
    logic [31:0] t;
    logic [31:0] s;
    t = a + k;
    s = 32'd0;
    for (int i = 0; i < 8; i++) begin
      s = s | (32'(sb[i][(t >> (4*i)) & 32'hF]) << (4*i));
    end
    return (s << 11) | (s >> 21);
  endfunction

  // Standard Magma encryption: K1..K8 three times, then K8..K1
  function automatic logic [63:0] ref_encrypt(input logic [63:0] p, input logic [255:0] k);
    logic [31:0] a1, a0, tmp;
    int j;
    a1 = p[63:32];
    a0 = p[31:0];
    for (int i = 0; i < 32; i++) begin
      j   = (i < 24) ? (i % 8) : (7 - (i % 8));
      tmp = a0;
      a0  = ref_g(a0, k[255 - 32*j -: 32]) ^ a1;
      a1  = tmp;
    end
    return {a0, a1};
  endfunction

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // mode 0: plain; 1: inputs mutated after the start edge; 2: extra starts during RUN
  task automatic run_block(input logic [63:0] din, input logic [255:0] k,
                           input logic [63:0] exp, input string tag, input int mode);
    int errs;
    errs    = 0;
    data_in = din;
    key     = k;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (mode == 1) begin
      data_in = '1;
      key     = '1;
    end
    for (int c = 1; c <= 32; c++) begin
      if (mode == 2 && (c == 5 || c == 20)) begin
        start   = 1'b1;
        data_in = {$urandom, $urandom};
        key     = rand_key();
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (c < 32) begin
        if (done !== 1'b0 || busy !== 1'b1) errs++;
      end
    end
    check_val({tag, "_running"}, 64'(errs), 64'd0);
    check_val({tag, "_done"}, {63'd0, done}, 64'd1);
    check_val({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check_val({tag, "_data"}, data_out, exp);
    @(posedge clk);
    #1;
    check_val({tag, "_done_drop"}, {63'd0, done}, 64'd0);
    check_val({tag, "_data_hold"}, data_out, exp);
  endtask

  initial begin
    int errs;
    logic [63:0]  p;
    logic [255:0] k;
    tests_run    = 0;
    tests_failed = 0;
    clk     = 1'b0;
    reset_  = 1'b0;
    start   = 1'b0;
    data_in = 64'd0;
    key     = 256'd0;
    #1;
    check_val("rst_data", data_out, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ = 1'b1;

    // start on the first edge after reset release
    run_block(CT_STD, KEY_STD, PT_STD, "std", 0);
    run_block(CT_STD, KEY_STD, PT_STD, "mutate", 1);
    run_block(CT_STD, KEY_STD, PT_STD, "start_in_run", 2);

    // start held high: one block every 34 cycles
    errs    = 0;
    data_in = CT_STD;
    key     = KEY_STD;
    start   = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 101; c++) begin
      @(posedge clk);
      #1;
      if (c == 32 || c == 66 || c == 100) begin
        check_val("b2b_done", {63'd0, done}, 64'd1);
        check_val("b2b_data", data_out, PT_STD);
      end else if (done !== 1'b0) begin
        errs++;
      end
      if (c == 100) start = 1'b0;
    end
    check_val("b2b_extra_done", 64'(errs), 64'd0);

    // reset in the middle of a block
    data_in = CT_STD;
    key     = KEY_STD;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    reset_ = 1'b0;
    #1;
    check_val("midrst_data", data_out, 64'd0);
    check_val("midrst_done", {63'd0, done}, 64'd0);
    check_val("midrst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_ = 1'b1;
    run_block(CT_STD, KEY_STD, PT_STD, "after_rst", 0);

    // random round trips through the reference encryptor
    for (int n = 0; n < 1000; n++) begin
      p = {$urandom, $urandom};
      k = rand_key();
      run_block(ref_encrypt(p, k), k, p, "roundtrip", 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/magma_decrypt.md
MAGMA_DECRYPT -- requirements
Module: magma_decrypt

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, the block's only clock.
REQ-002 SHALL have port: reset_  input  1  reset; the reset is asynchronous and active-low.
REQ-003 SHALL have port: start  input  1  request to decrypt data_in under key; sampled only in IDLE.
REQ-004 SHALL have port: data_in  input  64  ciphertext block; [63:32] is a1 (high half), [31:0] is a0 (low half).
REQ-005 SHALL have port: key  input  256  key; K1=key[255:224], K2=key[223:192], ..., K8=key[31:0].
REQ-006 SHALL have port: data_out  output  64  plaintext; registered; holds its value until the next completion.
REQ-007 SHALL have port: done  output  1  one-cycle pulse marking the cycle in which data_out becomes valid.
REQ-008 SHALL have port: busy  output  1  high while a block is in progress; start is ignored while busy is high.

Function
REQ-009 SHALL implement GOST R 34.12-2015 Magma decryption: 32 Feistel rounds, one round per clock.
REQ-010 SHALL have FSM states IDLE, RUN and FIN; transitions are IDLE->RUN on start, RUN->FIN after round 31, FIN->IDLE unconditionally.
REQ-011 SHALL, in IDLE with start=1, register data_in into a1/a0 and all of key into an internal key register, clear the round counter, and assert busy on the same edge.
REQ-012 SHALL use only the internal key copy; changes on key or data_in after the start edge SHALL NOT affect the result.
REQ-013 SHALL use a 5-bit round counter r (0..31) in RUN and increment it by 1 per cycle, with no wrap beyond 31.
REQ-014 SHALL select the round key as K(r+1) for r<8 and K(8-(r mod 8)) for r>=8, giving the order K1..K8, then K8..K1 three times.
REQ-015 SHALL compute per round t = (a0 + Kr) mod 2^32 as a 32-bit sum with the carry discarded.
REQ-016 SHALL substitute t through pi0..pi7 of GOST R 34.12-2015: pi0 on t[3:0], ..., pi7 on t[31:28].
REQ-017 SHALL rotate the substituted word left by 11 bits to form g.
REQ-018 SHALL update the halves each round as a1 <= a0, a0 <= g xor a1, using a1/a0 register values from the start of that cycle, so there is no intra-round pipelining.
REQ-019 SHALL, after round 31 (FIN entry edge), load data_out <= {a0, a1} (final swap undone), assert done for exactly one cycle and deassert busy on that same edge.
REQ-020 SHALL use the following latency: start sampled at edge N -> rounds on edges N+1..N+32 -> data_out valid and done=1 after edge N+32 -> done=0 after edge N+33.
REQ-021 SHALL ignore start while in RUN, leaving the running operation and its result undisturbed.
REQ-022 SHALL ignore start while in FIN; a new start is accepted in the first IDLE cycle, so back-to-back blocks have a period of 34 cycles.
REQ-023 SHALL keep done low at all times other than the single FIN cycle.
REQ-024 SHALL NOT change data_out in any cycle other than the FIN entry edge.
REQ-025 SHALL give the same 32-cycle behaviour to a start held high continuously, re-triggering from each IDLE cycle.

Reset
REQ-026 SHALL, on reset_ low, immediately and asynchronously force state=IDLE, r=0, a1=a0=0, internal key=0, data_out=0, done=0 and busy=0.
REQ-027 SHALL, on reset_ low mid-operation (RUN or FIN), abort the block with no done pulse and no data_out update.
REQ-028 SHALL accept start on the first clock edge after reset_ deasserts, treating it as a normal IDLE sample.

Verification
REQ-029 SHALL be verified with the standard vector: key=ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, data_in=4ee901e5c2d8ca3d, start pulse at edge N -> done=1 after edge N+32, data_out=fedcba9876543210, busy low in the same cycle.
REQ-030 SHALL be verified with input mutation: the REQ-029 stimulus, with data_in and key driven to all-ones from edge N+1 -> data_out=fedcba9876543210 unchanged.
REQ-031 SHALL be verified with start during RUN: start pulses at edges N+5 and N+20 with other data -> one done after edge N+32 only, data_out=fedcba9876543210.
REQ-032 SHALL be verified with back-to-back starts: start held high with REQ-029 inputs -> done pulses after edges N+32, N+66, N+100, each with data_out=fedcba9876543210.
REQ-033 SHALL be verified with mid-run reset: reset_ low at N+16 for 2 cycles -> data_out=0, done and busy 0 immediately; a restart afterwards yields the correct result 32 edges later.
REQ-034 SHALL be verified with a round trip: random 64-bit block P encrypted by a golden Magma model under random key K, then decrypted by the block -> data_out=P, for 1000 random (P, K) pairs.
